// File: rtl/vit_pkg.sv
// Shared types and default constants for the Viterbi decoder input path.
// The frame controller state type lives here so other blocks can decode it.
package vit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      TAIL  = 2'd2,
      DRAIN = 2'd3
   } vit_ictl_state_t;

   localparam int VIT_SYM_W     = 2;
   localparam int VIT_WORD_W    = 16;
   localparam int VIT_TAIL_SYMS = 6;

endpackage

// File: rtl/vit_sym_packer.sv
// Symbol-to-word packer: shifts symbols into an assembly register and moves
// each completed word straight into a single-entry output register.
module vit_sym_packer
   import vit_pkg::*;
#(
   parameter int SYM_W  = VIT_SYM_W,
   parameter int WORD_W = VIT_WORD_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              push,
   input  logic [SYM_W-1:0]  sym,
   input  logic              mark_sof,
   input  logic              mark_eof,
   input  logic              word_ready,
   output logic              can_push,
   output logic              word_done,
   output logic [WORD_W-1:0] word,
   output logic              word_valid,
   output logic              word_sof,
   output logic              word_eof
);

   localparam int SPW    = WORD_W / SYM_W;
   localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
   localparam int ASM_W  = WORD_W - SYM_W;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPW - 1);

   logic [SLOT_W-1:0] slot;
   logic [ASM_W-1:0]  assembly;
   logic [WORD_W-1:0] shifted;
   logic              at_last;
   logic              consume;
   logic              pushed;

   assign shifted   = {assembly, sym};
   assign at_last   = (slot == LAST_SLOT);
   assign consume   = word_valid && word_ready;
   // Only the symbol that completes a word needs the output register free.
   assign can_push  = !(at_last && word_valid && !word_ready);
   assign pushed    = push && can_push;
   assign word_done = pushed && at_last;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         slot     <= '0;
         assembly <= '0;
      end else if (pushed) begin
         slot     <= at_last ? '0 : slot + SLOT_W'(1);
         assembly <= shifted[ASM_W-1:0];
      end
   end

   // Output register: a completing word overwrites a word being consumed, no bubble.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         word       <= '0;
         word_valid <= 1'b0;
         word_sof   <= 1'b0;
         word_eof   <= 1'b0;
      end else if (word_done) begin
         word       <= shifted;
         word_valid <= 1'b1;
         word_sof   <= mark_sof;
         word_eof   <= mark_eof;
      end else if (consume) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/vit_frame_ctrl.sv
// Input frame controller: accepts channel symbols, appends the trellis
// termination tail, zero-pads the last word and frames words with sof/eof.
module vit_frame_ctrl
   import vit_pkg::*;
#(
   parameter int SYM_W     = VIT_SYM_W,
   parameter int WORD_W    = VIT_WORD_W,
   parameter int TAIL_SYMS = VIT_TAIL_SYMS,
   parameter int LEN_W     = 12
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_frame_start,
   input  logic [LEN_W-1:0]  i_frame_len,
   input  logic              i_sym_valid,
   input  logic [SYM_W-1:0]  i_sym,
   output logic              o_sym_ready,
   output logic [WORD_W-1:0] o_word,
   output logic              o_word_valid,
   input  logic              i_word_ready,
   output logic              o_word_sof,
   output logic              o_word_eof,
   output logic              o_busy,
   output logic              o_err_start
);

   localparam int SPW    = WORD_W / SYM_W;
   localparam int TAIL_W = $clog2(TAIL_SYMS + SPW) + 1;
   localparam logic [TAIL_W-1:0] TAIL_LIM = TAIL_W'(TAIL_SYMS);

   vit_ictl_state_t   state;
   logic [LEN_W-1:0]  frame_len;
   logic [LEN_W-1:0]  data_cnt;
   logic [LEN_W-1:0]  data_next;
   logic [TAIL_W-1:0] tail_cnt;
   logic [TAIL_W-1:0] tail_next;
   logic              first_word;
   logic              push;
   logic [SYM_W-1:0]  push_sym;
   logic              mark_eof;
   logic              can_push;
   logic              word_done;
   logic              sym_acc;

   assign data_next = data_cnt + LEN_W'(1);
   assign tail_next = tail_cnt + TAIL_W'(1);

   always_comb begin
      push     = 1'b0;
      push_sym = '0;
      mark_eof = 1'b0;
      case (state)
         LOAD: begin
            push     = i_sym_valid;
            push_sym = i_sym;
         end
         TAIL: begin
            push     = 1'b1;
            // Zeros past the tail length are pad; the word holding the last tail zero ends the frame.
            mark_eof = (tail_next >= TAIL_LIM);
         end
         default: ;
      endcase
   end

   assign o_sym_ready = (state == LOAD) && can_push;
   assign sym_acc     = o_sym_ready && i_sym_valid;
   assign o_busy      = (state != IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         frame_len   <= '0;
         data_cnt    <= '0;
         tail_cnt    <= '0;
         first_word  <= 1'b0;
         o_err_start <= 1'b0;
      end else begin
         o_err_start <= i_frame_start && (state != IDLE);
         case (state)
            IDLE: begin
               if (i_frame_start) begin
                  frame_len  <= i_frame_len;
                  data_cnt   <= '0;
                  tail_cnt   <= '0;
                  first_word <= 1'b1;
                  state      <= (i_frame_len == '0) ? TAIL : LOAD;
               end
            end
            LOAD: begin
               if (sym_acc) begin
                  data_cnt <= data_next;
                  if (data_next == frame_len) state <= TAIL;
               end
            end
            TAIL: begin
               if (can_push) begin
                  tail_cnt <= tail_next;
                  if (word_done && mark_eof) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (o_word_valid && i_word_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (word_done) first_word <= 1'b0;
      end
   end

   vit_sym_packer #(
      .SYM_W  (SYM_W),
      .WORD_W (WORD_W)
   ) u_packer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .push       (push),
      .sym        (push_sym),
      .mark_sof   (first_word),
      .mark_eof   (mark_eof),
      .word_ready (i_word_ready),
      .can_push   (can_push),
      .word_done  (word_done),
      .word       (o_word),
      .word_valid (o_word_valid),
      .word_sof   (o_word_sof),
      .word_eof   (o_word_eof)
   );

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Randomized bench for vit_frame_ctrl with a frame-level reference model.
module tb_vit_frame_ctrl;

   localparam int SYM_W     = 2;
   localparam int WORD_W    = 16;
   localparam int TAIL_SYMS = 6;
   localparam int LEN_W     = 12;
   localparam int SPW       = WORD_W / SYM_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_frame_start = 1'b0;
   logic [LEN_W-1:0]  i_frame_len = '0;
   logic              i_sym_valid = 1'b0;
   logic [SYM_W-1:0]  i_sym = '0;
   logic              o_sym_ready;
   logic [WORD_W-1:0] o_word;
   logic              o_word_valid;
   logic              i_word_ready = 1'b1;
   logic              o_word_sof;
   logic              o_word_eof;
   logic              o_busy;
   logic              o_err_start;

   always #5 clk = ~clk;

   vit_frame_ctrl #(
      .SYM_W(SYM_W), .WORD_W(WORD_W), .TAIL_SYMS(TAIL_SYMS), .LEN_W(LEN_W)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(i_frame_start),
      .i_frame_len(i_frame_len), .i_sym_valid(i_sym_valid), .i_sym(i_sym),
      .o_sym_ready(o_sym_ready), .o_word(o_word), .o_word_valid(o_word_valid),
      .i_word_ready(i_word_ready), .o_word_sof(o_word_sof), .o_word_eof(o_word_eof),
      .o_busy(o_busy), .o_err_start(o_err_start)
   );

   typedef struct packed {
      logic [WORD_W-1:0] w;
      logic              sof;
      logic              eof;
   } exp_t;

   exp_t             exp_q[$];
   logic [SYM_W-1:0] fsyms [0:255];
   int vectors = 0;
   int miscompares = 0;
   int err_seen = 0;
   int rdy_mode = 0;
   int stall_first = 0;
   int stall_len = 0;
   int hold_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int nwords(input int len);
      return (len + TAIL_SYMS + SPW - 1) / SPW;
   endfunction

   // Word w of a frame: data symbols, then zeros (tail and pad), first symbol in the MSBs.
   function automatic logic [WORD_W-1:0] calc_word(input int len, input int w);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int k = 0; k < SPW; k++) begin
         int idx;
         idx = w * SPW + k;
         if (idx < len) r[WORD_W-1-k*SYM_W -: SYM_W] = fsyms[idx];
      end
      return r;
   endfunction

   task automatic build_frame(input int len);
      exp_t e;
      int   nw;
      nw = nwords(len);
      for (int w = 0; w < nw; w++) begin
         e.w   = calc_word(len, w);
         e.sof = (w == 0);
         e.eof = (w == nw - 1);
         exp_q.push_back(e);
      end
   endtask

   // Word-ready driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_first != 0 && o_word_valid) begin
            stall_first = 0;
            hold_cnt = stall_len;
         end
         if (hold_cnt > 0) begin
            i_word_ready = 1'b0;
            hold_cnt--;
         end else begin
            i_word_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
         end
      end
   end

   // Reference model and per-cycle compare.
   initial begin
      int   m_phase;
      int   m_len;
      int   m_acc;
      logic exp_err;
      logic exp_ready;
      logic was_idle;
      logic held_v;
      logic [WORD_W+1:0] held;
      exp_t e;
      m_phase = 0; m_len = 0; m_acc = 0;
      exp_err = 1'b0; held_v = 1'b0; held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_word", 32'(o_word), 32'(0));
            check("rst_flags", 32'({o_word_valid, o_word_sof, o_word_eof}), 32'(0));
            check("rst_ctrl", 32'({o_busy, o_sym_ready, o_err_start}), 32'(0));
            m_phase = 0; exp_err = 1'b0; held_v = 1'b0;
            exp_q.delete();
         end else begin
            if (o_err_start) err_seen++;
            exp_ready = (m_phase == 1) &&
                        !(((m_acc % SPW) == SPW - 1) && o_word_valid && !i_word_ready);
            check("busy", 32'(o_busy), 32'(m_phase != 0));
            check("sym_ready", 32'(o_sym_ready), 32'(exp_ready));
            check("err_start", 32'(o_err_start), 32'(exp_err));
            if (held_v)
               check("hold", 32'({o_word_valid, o_word, o_word_sof, o_word_eof}),
                     32'({1'b1, held}));
            held_v = o_word_valid && !i_word_ready;
            held   = {o_word, o_word_sof, o_word_eof};
            was_idle = (m_phase == 0);
            exp_err  = i_frame_start && !was_idle;
            if (o_word_valid && i_word_ready) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_word: got 0x%0h, expected no word (t=%0t)", o_word, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("word", 32'(o_word), 32'(e.w));
                  check("sof", 32'(o_word_sof), 32'(e.sof));
                  check("eof", 32'(o_word_eof), 32'(e.eof));
                  if (e.eof) m_phase = 0;
               end
            end
            if (m_phase == 1 && i_sym_valid && o_sym_ready) begin
               m_acc++;
               if (m_acc == m_len) m_phase = 2;
            end
            if (was_idle && i_frame_start) begin
               m_len   = int'(i_frame_len);
               m_acc   = 0;
               m_phase = (m_len == 0) ? 2 : 1;
            end
         end
      end
   end

   task automatic run_frame(input int len, input int vprob, input int err_at, input int abort_at);
      int   idx;
      int   guard;
      logic acc;
      logic err_done;
      build_frame(len);
      i_frame_start = 1'b1;
      i_frame_len   = LEN_W'(len);
      i_sym_valid   = 1'b0;
      @(posedge clk);
      #1;
      i_frame_start = 1'b0;
      idx = 0; guard = 0; err_done = 1'b0;
      while (idx < len) begin
         if (idx == abort_at) begin
            rst_n = 1'b0;
            i_sym_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end
         i_sym_valid = ($urandom_range(0, 99) < vprob);
         i_sym = fsyms[idx];
         if (idx == err_at && !err_done) begin
            i_frame_start = 1'b1;
            i_frame_len   = LEN_W'($urandom_range(0, 50));
            err_done      = 1'b1;
         end
         @(negedge clk);
         acc = i_sym_valid && o_sym_ready;
         @(posedge clk);
         #1;
         i_frame_start = 1'b0;
         if (acc) idx++;
         guard++;
         if (guard > 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL sym_timeout: accepted %0d symbols, expected %0d", idx, len);
            break;
         end
      end
      i_sym_valid = 1'b0;
      guard = 0;
      while ((o_busy || exp_q.size() != 0) && guard < 500) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("frame_drained", 32'(guard < 500), 32'(1));
      check("words_left", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      int e0;
      int len;
      int pat0 [8];
      pat0 = '{3, 2, 1, 0, 3, 2, 1, 0};
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // len=8, 3,2,1,0 pattern
      for (int i = 0; i < 8; i++) fsyms[i] = SYM_W'(pat0[i]);
      check("model_w0_len8", 32'(calc_word(8, 0)), 32'h0000_E4E4);
      check("model_w1_len8", 32'(calc_word(8, 1)), 32'h0000_0000);
      check("model_nw_len8", 32'(nwords(8)), 32'(2));
      run_frame(8, 100, -1, -1);

      // len=3 of ones
      for (int i = 0; i < 3; i++) fsyms[i] = 2'd1;
      check("model_w0_len3", 32'(calc_word(3, 0)), 32'h0000_5400);
      check("model_nw_len3", 32'(nwords(3)), 32'(2));
      run_frame(3, 100, -1, -1);

      // empty frame: one all-tail word with sof and eof
      check("model_nw_len0", 32'(nwords(0)), 32'(1));
      run_frame(0, 100, -1, -1);

      // output back-pressure at the first word, short and long holds
      for (int i = 0; i < 16; i++) fsyms[i] = SYM_W'($urandom_range(0, 3));
      stall_len = 5; stall_first = 1;
      run_frame(16, 100, -1, -1);
      for (int i = 0; i < 16; i++) fsyms[i] = SYM_W'($urandom_range(0, 3));
      stall_len = 12; stall_first = 1;
      run_frame(16, 100, -1, -1);

      // frame start while loading
      for (int i = 0; i < 20; i++) fsyms[i] = SYM_W'($urandom_range(0, 3));
      e0 = err_seen;
      run_frame(20, 100, 6, -1);
      check("err_pulse_count", 32'(err_seen - e0), 32'(1));

      // reset mid-frame, then a clean frame
      for (int i = 0; i < 10; i++) fsyms[i] = SYM_W'($urandom_range(0, 3));
      run_frame(10, 100, -1, 5);
      for (int i = 0; i < 8; i++) fsyms[i] = SYM_W'(pat0[i]);
      run_frame(8, 100, -1, -1);

      // randomized frames with random valid and ready
      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(0, 40);
         for (int i = 0; i < len; i++) fsyms[i] = SYM_W'($urandom_range(0, 3));
         rdy_mode = $urandom_range(0, 1);
         run_frame(len, $urandom_range(40, 100),
                   (len > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1, -1);
      end
      rdy_mode = 0;
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vit_frame_ctrl.md
# vit_frame_ctrl

Input frame controller for the Viterbi decoder front end. It accepts a handshaked stream of SYM_W-bit channel symbols and packs SPW = WORD_W/SYM_W symbols per output word. It appends TAIL_SYMS zero tail symbols (K-1 trellis termination), zero-pads the last word, and presents words to the decoder core under a valid/ready handshake with start/end-of-frame flags. It sits between the channel interface and the branch-metric/ACS input.

## Interface
- SYM_W, 2, bits per channel symbol (rate-1/2 hard decision)
- WORD_W, 16, output word width; must be an integer multiple of SYM_W
- TAIL_SYMS, 6, zero symbols appended per frame (K=7)
- LEN_W, 12, width of the frame length field in symbols
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_frame_start  in  1  one-cycle pulse that starts a frame and samples i_frame_len
- i_frame_len  in  LEN_W  number of data symbols in the frame; 0 is legal
- i_sym_valid  in  1  symbol valid
- i_sym  in  SYM_W  channel symbol
- o_sym_ready  out  1  symbol accepted when i_sym_valid && o_sym_ready
- o_word  out  WORD_W  packed word; first symbol of the word in [WORD_W-1 -: SYM_W]
- o_word_valid  out  1  word valid
- i_word_ready  in  1  word consumed when o_word_valid && i_word_ready
- o_word_sof  out  1  qualifies o_word: first word of frame
- o_word_eof  out  1  qualifies o_word: last word of frame
- o_busy  out  1  high whenever the state is not IDLE
- o_err_start  out  1  one-cycle pulse when i_frame_start arrives while busy

## Operation
- States: IDLE, LOAD, TAIL, DRAIN.
- IDLE, i_frame_start: latch i_frame_len, clear the counters, then go to LOAD (or to TAIL if the length is 0).
- LOAD: o_sym_ready = !(slot==SPW-1 && o_word_valid && !i_word_ready). Each accepted symbol shifts into the assembly register and increments slot and data_cnt.
  - After the last data symbol is accepted (data_cnt reaches the latched length), go to TAIL.
- TAIL: insert one zero symbol per cycle, using the same stall rule as LOAD; o_sym_ready=0.
  - tail_cnt counts inserted zeros. Zeros beyond TAIL_SYMS are pad.
  - When tail_cnt ≥ TAIL_SYMS and a word completes, that word carries eof; go to DRAIN.
- Word completion: when the symbol or zero lands in slot SPW-1, {assembly, new_sym} is written directly to the output register and slot wraps to 0.
  - The write happens only if the output register is empty or is being consumed in the same cycle; otherwise the state stalls.
- The first completed word of a frame carries sof. A single-word frame carries both sof and eof.
- DRAIN: when the eof word is consumed, go to IDLE.
- i_frame_start while busy: ignored. o_err_start pulses for one cycle and the frame in progress is unaffected.
- Words per frame: ceil((len+TAIL_SYMS)/SPW).
- Counter widths: slot is $clog2(SPW); data_cnt is LEN_W; tail_cnt is $clog2(TAIL_SYMS+SPW)+1.

## Timing
- Reset values: all outputs 0, the assembly and output registers 0, state IDLE.
  - A reset mid-frame discards all partial and pending words; there is no resume.
- o_sym_ready rises in the cycle after the i_frame_start edge.
- The word completed at edge N has o_word_valid high from edge N. Throughput is 1 symbol per cycle and 1 word per SPW cycles with no stall while i_word_ready=1.
- o_word, o_word_sof and o_word_eof stay stable while o_word_valid && !i_word_ready.
- Simultaneous consume and new word completion in the same cycle: o_word_valid stays high and the new word is loaded with no bubble.
- The cycle after the eof word is consumed, state is IDLE and o_busy=0. A new i_frame_start is accepted in that same IDLE cycle.

## Structure
- Package vit_pkg:
  - the state enum vit_ictl_state_t {IDLE, LOAD, TAIL, DRAIN};
  - default constants VIT_SYM_W=2, VIT_WORD_W=16, VIT_TAIL_SYMS=6.
- SPW and the counter widths are local to the module, derived from its parameters.
- Sub-module vit_sym_packer:
  - contents: the assembly shift register, the slot counter and the output register with its valid/sof/eof flags;
  - control inputs: push, sym, mark_sof, mark_eof;
  - status outputs: can_push, word_done.
- The controller FSM and the frame/tail counters stay in vit_frame_ctrl.

## Test plan
- len=8, symbols 3,2,1,0,3,2,1,0, i_word_ready=1 → word 0x E4E4 with sof=1, eof=0; then word 0x0000 with eof=1; then IDLE.
- len=3, symbols 1,1,1 → 0x5400 (sof), then 0x0000 (eof); exactly 2 words.
- len=0 → a single word 0x0000 with sof=1 and eof=1, o_busy low 1 cycle after consumption.
- len=16, i_word_ready held low for 5 cycles at the first word → o_sym_ready=0 only while slot=7 and the output is held. The output stays stable, and no symbol is lost or duplicated (compare against a scoreboard).
- i_frame_start during LOAD → o_err_start is one 1-cycle pulse and the current frame's words are unchanged.
- Reset asserted after 5 symbols of len=10 → outputs 0 and state IDLE. A following len=8 frame produces correct words from a clean state.
